// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; show-ahead read of the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_wrOut,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int CW = $clog2(CLK_DIV);

  uart_tx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic                      tx_q, tx_d;
  logic                      ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  logic       push, pop, full, empty, last;
  logic [7:0] head;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (i_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign last  = (cnt_q == CW'(CLK_DIV - 1));
  // A pop in the same cycle frees the slot this write lands in.
  assign push  = i_wrOut & (~full | pop);
  assign ovf_d = ovf_q | (i_wrOut & full & ~pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (last) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (last) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the next state so o_tx changes on the transition edge.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = (state_q != IDLE) | ~empty;
  assign o_full     = full;
  assign o_overflow = ovf_q;

endmodule
